// File: rtl/sisc_exec_core_if.sv
// Bundle of the execution-slice signals shared by the register file, status register and memory.
// slave is the core's view; master is the surrounding datapath (or a testbench) driving it.
interface sisc_exec_core_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] rsa;
  logic [WIDTH-1:0] rsb;
  logic [WIDTH-1:0] read_data;
  logic [3:0]       stat;
  logic             rf_we;
  logic [1:0]       alu_op;
  logic             wb_sel;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       cc;
  logic             stat_en;
  logic             halted;

  modport slave (
    input  ir, rsa, rsb, read_data, stat,
    output rf_we, alu_op, wb_sel, write_data, alu_result, cc, stat_en, halted
  );

  modport master (
    output ir, rsa, rsb, read_data, stat,
    input  rf_we, alu_op, wb_sel, write_data, alu_result, cc, stat_en, halted
  );
endinterface

// File: rtl/sisc_exec_core.sv
// SISC execution slice: sequencing FSM, 32-bit ALU with {C,N,V,Z} flags and write-back mux.
// Define ALU_MUL_EN to turn function code 1000 into an unsigned multiply.
module sisc_exec_core #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_f,
  sisc_exec_core_if.slave  bus
);

  typedef enum logic [2:0] {
    START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] alu_result_reg;
  logic             rf_we_reg;
  logic             wb_sel_reg;
  logic             halted_reg;

  logic [3:0]       opcode;
  logic [3:0]       mm;
  logic             is_alu_opc;
  logic             func_ok;
  logic             valid_op;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_res;
  logic             c_flag;
  logic             v_flag;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  assign opcode     = bus.ir[31:28];
  assign mm         = bus.ir[27:24];
  assign is_alu_opc = (opcode == 4'h1) || (opcode == 4'h2);
`ifdef ALU_MUL_EN
  assign func_ok    = (mm <= 4'h8);
`else
  assign func_ok    = ~mm[3];
`endif
  assign valid_op   = is_alu_opc && func_ok;
  assign operand_b  = (opcode == 4'h2) ? {{(WIDTH-16){bus.ir[15]}}, bus.ir[15:0]} : bus.rsb;

  assign sum_ext    = {1'b0, bus.rsa} + {1'b0, operand_b};
  assign diff_ext   = {1'b0, bus.rsa} - {1'b0, operand_b};

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] product;
  assign product = bus.rsa * operand_b;
`endif

  always_comb begin
    alu_res = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (mm)
      4'h0: begin
        alu_res = sum_ext[WIDTH-1:0];
        c_flag  = sum_ext[WIDTH];
        v_flag  = (bus.rsa[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != bus.rsa[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff_ext[WIDTH-1:0];
        // The extra bit is the borrow, so carry is its complement (A >= B unsigned).
        c_flag  = ~diff_ext[WIDTH];
        v_flag  = (bus.rsa[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (diff_ext[WIDTH-1] != bus.rsa[WIDTH-1]);
      end
      4'h2: alu_res = bus.rsa & operand_b;
      4'h3: alu_res = bus.rsa | operand_b;
      4'h4: alu_res = bus.rsa ^ operand_b;
      4'h5: alu_res = ~bus.rsa;
      4'h6: alu_res = bus.rsa << operand_b[4:0];
      4'h7: alu_res = bus.rsa >> operand_b[4:0];
`ifdef ALU_MUL_EN
      4'h8: begin
        alu_res = product[WIDTH-1:0];
        c_flag  = |product[2*WIDTH-1:WIDTH];
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_reg      <= START0;
      alu_result_reg <= '0;
      rf_we_reg      <= 1'b0;
      wb_sel_reg     <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      rf_we_reg  <= 1'b0;
      wb_sel_reg <= 1'b0;
      case (state_reg)
        START0:  state_reg <= START1;
        START1:  state_reg <= FETCH;
        FETCH:   state_reg <= DECODE;
        DECODE: begin
          if (opcode == 4'hF) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg  <= EXECUTE;
          end
        end
        EXECUTE: begin
          state_reg      <= MEM;
          alu_result_reg <= alu_res;
        end
        // Write-back strobes are registered here so they appear exactly in WRITEBACK.
        MEM: begin
          state_reg  <= WRITEBACK;
          rf_we_reg  <= valid_op;
          wb_sel_reg <= valid_op;
        end
        WRITEBACK: state_reg <= FETCH;
        HALT:      state_reg <= HALT;
        default:   state_reg <= START0;
      endcase
    end
  end

  // alu_op follows ir combinationally because ir is only guaranteed stable from DECODE on.
  always_comb begin
    bus.alu_op = 2'b00;
    if ((state_reg == DECODE) || (state_reg == EXECUTE) ||
        (state_reg == MEM) || (state_reg == WRITEBACK)) begin
      if (opcode == 4'h1)      bus.alu_op = 2'b01;
      else if (opcode == 4'h2) bus.alu_op = 2'b10;
    end
  end

  assign bus.cc         = {c_flag, alu_res[WIDTH-1], v_flag, (alu_res == '0)};
  assign bus.stat_en    = (state_reg == EXECUTE) && valid_op;
  assign bus.rf_we      = rf_we_reg;
  assign bus.wb_sel     = wb_sel_reg;
  assign bus.halted     = halted_reg;
  assign bus.alu_result = alu_result_reg;
  assign bus.write_data = wb_sel_reg ? alu_result_reg : bus.read_data;

endmodule

// File: tb/tb_sisc_exec_core.sv
// Self-checking bench for sisc_exec_core: directed cases plus random instructions checked
// against an arithmetic reference model of the ALU and a cycle-by-cycle view of the sequencer.
module tb_sisc_exec_core;

  logic clk;
  logic rst_f;
  int   n_checks;
  int   n_fail;

  sisc_exec_core_if #(.WIDTH(32)) bus ();

  sisc_exec_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU built from signed/unsigned 64-bit arithmetic.
  function automatic void ref_alu(input logic [31:0] ir, input logic [31:0] a,
                                  input logic [31:0] rsb, output logic [31:0] res,
                                  output logic [3:0] cc, output logic valid);
    logic [3:0]         opc;
    logic [3:0]         mm;
    logic signed [15:0] imm_s;
    logic [31:0]        b;
    longint unsigned    wide;
    longint             sa;
    longint             sb;
    longint             sw;
    logic               c;
    logic               v;
    bit                 mul_en;
`ifdef ALU_MUL_EN
    mul_en = 1'b1;
`else
    mul_en = 1'b0;
`endif
    opc   = ir[31:28];
    mm    = ir[27:24];
    imm_s = ir[15:0];
    b     = (opc == 4'h2) ? 32'(imm_s) : rsb;
    sa    = $signed(a);
    sb    = $signed(b);
    c     = 1'b0;
    v     = 1'b0;
    res   = 32'h0;
    case (mm)
      4'h0: begin
        wide = longint'(a) + longint'(b);
        res  = wide[31:0];
        c    = wide[32];
        sw   = sa + sb;
        v    = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
      end
      4'h1: begin
        res = a - b;
        c   = (a >= b);
        sw  = sa - sb;
        v   = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
      end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      4'h5: res = ~a;
      4'h6: res = a << b[4:0];
      4'h7: res = a >> b[4:0];
      4'h8: begin
        if (mul_en) begin
          wide = longint'(a) * longint'(b);
          res  = wide[31:0];
          c    = (wide >> 32) != 0;
        end
      end
      default: res = 32'h0;
    endcase
    valid = ((opc == 4'h1) || (opc == 4'h2)) && ((mm < 4'h8) || (mul_en && mm == 4'h8));
    cc    = {c, res[31], v, (res == 32'h0)};
  endfunction

  // Entered at the negedge of a FETCH cycle; leaves at the negedge of the next FETCH cycle.
  task automatic run_instr(input logic [31:0] ir, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] rdata);
    logic [31:0] exp_res;
    logic [3:0]  exp_cc;
    logic        valid;
    logic [1:0]  exp_op;
    logic        alu_opc;
    bus.ir        = ir;
    bus.rsa       = a;
    bus.rsb       = b;
    bus.read_data = rdata;
    bus.stat      = 4'($urandom_range(0, 15));
    ref_alu(ir, a, b, exp_res, exp_cc, valid);
    alu_opc = (ir[31:28] == 4'h1) || (ir[31:28] == 4'h2);
    exp_op  = (ir[31:28] == 4'h1) ? 2'b01 : (ir[31:28] == 4'h2) ? 2'b10 : 2'b00;
    $display("instr ir=%h rsa=%h rsb=%h exp_result=%h exp_cc=%b valid=%0d",
             ir, a, b, exp_res, exp_cc, valid);
    @(negedge clk);  // DECODE
    check("decode_alu_op", 32'(bus.alu_op), 32'(exp_op));
    check("decode_rf_we", 32'(bus.rf_we), 32'd0);
    check("decode_stat_en", 32'(bus.stat_en), 32'd0);
    if (ir[31:28] == 4'hF) begin
      @(negedge clk);  // HALT
      check("halt_flag", 32'(bus.halted), 32'd1);
      return;
    end
    @(negedge clk);  // EXECUTE
    check("exec_stat_en", 32'(bus.stat_en), 32'(valid));
    check("exec_alu_op", 32'(bus.alu_op), 32'(exp_op));
    if (valid) check("exec_cc", 32'(bus.cc), 32'(exp_cc));
    check("exec_rf_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);  // MEM
    if (alu_opc) check("mem_alu_result", bus.alu_result, valid ? exp_res : 32'h0);
    check("mem_write_data", bus.write_data, rdata);
    check("mem_rf_we", 32'(bus.rf_we), 32'd0);
    check("mem_stat_en", 32'(bus.stat_en), 32'd0);
    @(negedge clk);  // WRITEBACK
    check("wb_rf_we", 32'(bus.rf_we), 32'(valid));
    check("wb_sel", 32'(bus.wb_sel), 32'(valid));
    check("wb_write_data", bus.write_data, valid ? exp_res : rdata);
    check("wb_alu_op", 32'(bus.alu_op), 32'(exp_op));
    @(negedge clk);  // FETCH
    check("fetch_rf_we", 32'(bus.rf_we), 32'd0);
    check("fetch_alu_op", 32'(bus.alu_op), 32'd0);
  endtask

  // Called at a negedge with reset deasserted edges pending; ends at negedge in FETCH.
  task automatic release_to_fetch();
    rst_f = 1'b0;
    @(negedge clk);  // START1
    check("start1_rf_we", 32'(bus.rf_we), 32'd0);
    check("start1_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);  // FETCH
    check("start_fetch_rf_we", 32'(bus.rf_we), 32'd0);
    check("start_fetch_alu_op", 32'(bus.alu_op), 32'd0);
  endtask

  initial begin
    logic [31:0] r_ir;
    logic [3:0]  r_opc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    n_checks      = 0;
    n_fail        = 0;
    rst_f         = 1'b1;
    bus.ir        = 32'h0;
    bus.rsa       = 32'h0;
    bus.rsb       = 32'h0;
    bus.read_data = 32'hDEAD_BEEF;
    bus.stat      = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_stat_en", 32'(bus.stat_en), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_wb_sel", 32'(bus.wb_sel), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_alu_result", bus.alu_result, 32'h0);
    check("rst_write_data", bus.write_data, 32'hDEAD_BEEF);
    release_to_fetch();

    run_instr(32'h1012_0000, 32'd5, 32'd7, 32'h1111_2222);
    check("add_5_7", bus.alu_result, 32'h0000_000C);
    run_instr(32'h1112_0000, 32'd3, 32'd3, 32'h3333_4444);
    check("sub_3_3", bus.alu_result, 32'h0);
    run_instr(32'h1112_0000, 32'd0, 32'd1, 32'h5555_6666);
    check("sub_0_1", bus.alu_result, 32'hFFFF_FFFF);
    run_instr(32'h2012_FFFF, 32'd1, 32'h1234_5678, 32'h7777_8888);
    check("addi_1_m1", bus.alu_result, 32'h0);
    run_instr(32'h1012_0000, 32'h7FFF_FFFF, 32'd1, 32'h9999_AAAA);
    check("add_ovf", bus.alu_result, 32'h8000_0000);
    run_instr(32'h1612_0000, 32'hA5A5_0001, 32'h0000_0020, 32'h0);
    check("shl_by_zero", bus.alu_result, 32'hA5A5_0001);
    run_instr(32'h1912_0000, 32'd4, 32'd4, 32'hCAFE_0001);
    run_instr(32'h1812_0000, 32'h0001_0000, 32'h0001_0000, 32'hCAFE_0002);
    run_instr(32'h0000_0000, 32'd9, 32'd9, 32'hCAFE_0003);

    // Random instructions; small operands now and then so Z/C edge cases occur.
    for (int i = 0; i < 40; i++) begin
      r_opc = 4'($urandom_range(0, 5));
      if (r_opc > 4'h2) r_opc = (r_opc == 4'h5) ? 4'($urandom_range(3, 14)) : 4'h1;
      r_ir  = {r_opc, 4'($urandom_range(0, 9)), 8'($urandom), 16'($urandom)};
      r_a   = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r_b   = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_instr(r_ir, r_a, r_b, $urandom);
    end

    // Reset during EXECUTE must abort the instruction without a write.
    bus.ir  = 32'h1012_0000;
    bus.rsa = 32'd100;
    bus.rsb = 32'd200;
    @(negedge clk);  // DECODE
    @(negedge clk);  // EXECUTE
    rst_f = 1'b1;
    #1;
    check("abort_alu_result", bus.alu_result, 32'h0);
    check("abort_stat_en", 32'(bus.stat_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_rf_we", 32'(bus.rf_we), 32'd0);
    end
    $display("reset mid-instruction released");
    release_to_fetch();
    run_instr(32'h1312_0000, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0);

    // HALT holds with no writes until reset.
    run_instr(32'hF000_0000, 32'd1, 32'd2, 32'h0);
    for (int i = 0; i < 20; i++) begin
      bus.ir = {4'h1, 28'($urandom)};
      @(negedge clk);
      check("halt_hold", 32'(bus.halted), 32'd1);
      check("halt_rf_we", 32'(bus.rf_we), 32'd0);
    end
    $display("halt held for 20 cycles");
    rst_f = 1'b1;
    @(negedge clk);
    check("halt_reset_clears", 32'(bus.halted), 32'd0);
    release_to_fetch();
    run_instr(32'h2012_0010, 32'd1, 32'd0, 32'h0);
    check("post_halt_addi", bus.alu_result, 32'h0000_0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
